// File: rtl/ibex_fetch_pkg.sv
// Shared types and constants for the instruction fetch request controller.
package ibex_fetch_pkg;

  typedef enum logic {
    IDLE,
    WAIT_GNT
  } fetch_state_e;

  localparam logic [31:0] FETCH_WORD_INCR = 32'd4;
  localparam int          FETCH_MAX_REQS  = 4;

  function automatic logic [2:0] popcount(input logic [FETCH_MAX_REQS-1:0] v);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < FETCH_MAX_REQS; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ibex_fetch_outstanding_tracker.sv
// Thermometer tracker of outstanding bus responses with per-slot discard flags.
// Shift on rvalid happens before the grant sets the next free slot.
module ibex_fetch_outstanding_tracker
  import ibex_fetch_pkg::*;
#(
  parameter int NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                gnt,
  input  logic                rvalid,
  input  logic                branch,
  output logic [NUM_REQS-1:0] outstanding_q,
  output logic [NUM_REQS-1:0] discard_q,
  output logic [2:0]          live_cnt,
  output logic                head_valid
);

  logic [NUM_REQS-1:0] out_shift;
  logic [NUM_REQS-1:0] disc_shift;
  logic [NUM_REQS-1:0] set_bit;
  logic [NUM_REQS-1:0] out_d;
  logic [NUM_REQS-1:0] disc_d;

  always_comb begin
    out_shift  = rvalid ? (outstanding_q >> 1) : outstanding_q;
    disc_shift = rvalid ? (discard_q >> 1) : discard_q;
    // Lowest clear bit of a thermometer code; the new request is never stale.
    set_bit    = gnt ? (~out_shift & (out_shift + NUM_REQS'(1))) : '0;
    out_d      = out_shift | set_bit;
    disc_d     = disc_shift | (branch ? out_shift : '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= out_d;
      discard_q     <= disc_d;
    end
  end

  assign live_cnt   = popcount(FETCH_MAX_REQS'(outstanding_q & ~discard_q));
  assign head_valid = outstanding_q[0] & ~discard_q[0];

endmodule

// File: rtl/ibex_fetch_req_ctrl.sv
// Fetch request controller: word-aligned bus requests, stale-response filtering, FIFO push (0-cycle).
// Stalls requests on FIFO occupancy or NUM_REQS in flight; IBEX_FETCH_PERF_CNT_EN adds a grant-stall counter.
module ibex_fetch_req_ctrl
  import ibex_fetch_pkg::*;
#(
  parameter int NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_clear_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i,
`ifdef IBEX_FETCH_PERF_CNT_EN
  output logic [31:0]         perf_gnt_stall_o,
`endif
  output logic                busy_o
);

  fetch_state_e        state_q, state_d;
  logic [31:0]         fetch_addr_q;
  logic [31:0]         branch_addr;
  logic [NUM_REQS-1:0] outstanding_q;
  logic [NUM_REQS-1:0] discard_q;
  logic [2:0]          live_cnt;
  logic                head_valid;
  logic [3:0]          demand;
  logic                allowed;
  logic                gnt;

  ibex_fetch_outstanding_tracker #(
    .NUM_REQS(NUM_REQS)
  ) u_tracker (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .gnt          (gnt),
    .rvalid       (instr_rvalid_i),
    .branch       (branch_i),
    .outstanding_q(outstanding_q),
    .discard_q    (discard_q),
    .live_cnt     (live_cnt),
    .head_valid   (head_valid)
  );

  assign branch_addr = {addr_i[31:2], 2'b00};
  // A branch clears the FIFO this cycle, so its occupancy no longer counts.
  assign demand  = {1'b0, live_cnt}
                 + (branch_i ? 4'd0 : {1'b0, popcount(FETCH_MAX_REQS'(fifo_busy_i))});
  assign allowed = (demand < 4'(NUM_REQS)) & ~outstanding_q[NUM_REQS-1];

  always_comb begin
    state_d     = state_q;
    instr_req_o = 1'b0;
    case (state_q)
      IDLE: begin
        instr_req_o = req_i & allowed;
        if (instr_req_o && !instr_gnt_i) state_d = WAIT_GNT;
      end
      WAIT_GNT: begin
        instr_req_o = 1'b1;
        if (instr_gnt_i) state_d = IDLE;
      end
    endcase
  end

  assign gnt          = instr_req_o & instr_gnt_i;
  assign instr_addr_o = branch_i ? branch_addr : fetch_addr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (gnt) begin
        fetch_addr_q <= instr_addr_o + FETCH_WORD_INCR;
      end else if (branch_i) begin
        fetch_addr_q <= branch_addr;
      end
    end
  end

  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign fifo_valid_o = instr_rvalid_i & head_valid & ~branch_i;
  assign busy_o       = instr_req_o | (|outstanding_q);

`ifdef IBEX_FETCH_PERF_CNT_EN
  logic        req_q;
  logic [31:0] perf_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q      <= 1'b0;
      perf_cnt_q <= '0;
    end else begin
      req_q <= req_i;
      if (req_i && !req_q) begin
        perf_cnt_q <= '0;
      end else if (state_q == WAIT_GNT && perf_cnt_q != '1) begin
        perf_cnt_q <= perf_cnt_q + 32'd1;
      end
    end
  end

  assign perf_gnt_stall_o = perf_cnt_q;
`endif

  a_rvalid_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    instr_rvalid_i |-> outstanding_q[0]);
  a_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == WAIT_GNT) |-> instr_req_o);
  a_addr_aligned: assert property (@(posedge clk_i) disable iff (rst_i)
    instr_addr_o[1:0] == 2'b00);
  a_discard_subset: assert property (@(posedge clk_i) disable iff (rst_i)
    (discard_q & ~outstanding_q) == '0);

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Randomized and directed bench for ibex_fetch_req_ctrl against a request-queue reference model.
module tb_ibex_fetch_req_ctrl;

  localparam int NR = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_i = 1'b0;
  logic          branch_i = 1'b0;
  logic [31:0]   addr_i = '0;
  logic [NR-1:0] fifo_busy_i = '0;
  logic          fifo_clear_o, fifo_valid_o, fifo_err_o;
  logic [31:0]   fifo_addr_o, fifo_rdata_o;
  logic          instr_req_o;
  logic          instr_gnt_i = 1'b0;
  logic [31:0]   instr_addr_o;
  logic          instr_rvalid_i = 1'b0;
  logic [31:0]   instr_rdata_i = '0;
  logic          instr_err_i = 1'b0;
  logic          busy_o;
`ifdef IBEX_FETCH_PERF_CNT_EN
  logic [31:0]   perf_gnt_stall_o;
`endif

  always #5 clk_i = ~clk_i;

  ibex_fetch_req_ctrl #(.NUM_REQS(NR)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .branch_i      (branch_i),
    .addr_i        (addr_i),
    .fifo_busy_i   (fifo_busy_i),
    .fifo_clear_o  (fifo_clear_o),
    .fifo_valid_o  (fifo_valid_o),
    .fifo_addr_o   (fifo_addr_o),
    .fifo_rdata_o  (fifo_rdata_o),
    .fifo_err_o    (fifo_err_o),
    .instr_req_o   (instr_req_o),
    .instr_gnt_i   (instr_gnt_i),
    .instr_addr_o  (instr_addr_o),
    .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i (instr_rdata_i),
    .instr_err_i   (instr_err_i),
`ifdef IBEX_FETCH_PERF_CNT_EN
    .perf_gnt_stall_o(perf_gnt_stall_o),
`endif
    .busy_o        (busy_o)
  );

  // Reference model: queue of granted requests in bus order, each tagged stale or live.
  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } req_t;

  req_t        q[$];
  logic [31:0] m_next;
  bit          m_pend;
  logic [31:0] m_perf;
  bit          m_req_prev;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; req_i = 1'b0; branch_i = 1'b0; addr_i = '0; fifo_busy_i = '0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_err_i = 1'b0;
    #1;
    chk("rst_req", 32'(instr_req_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(fifo_valid_o), 32'd0);
`ifdef IBEX_FETCH_PERF_CNT_EN
    chk("rst_perf", perf_gnt_stall_o, 32'd0);
`endif
    q.delete();
    m_next = '0; m_pend = 0; m_perf = '0; m_req_prev = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic cycle(input bit req, input bit br, input logic [31:0] a,
                       input logic [NR-1:0] busy, input bit gnt, input bit rv, input bit err);
    int          live;
    bit          allowed, e_req, e_valid, g, rv_eff;
    logic [31:0] e_addr, ba;
    @(negedge clk_i);
    rv_eff = rv && (q.size() > 0);
    req_i = req; branch_i = br; addr_i = a; fifo_busy_i = busy;
    instr_gnt_i = gnt; instr_rvalid_i = rv_eff; instr_err_i = err;
    instr_rdata_i = (q.size() > 0) ? rd_of(q[0].addr) : 32'h0;
    #1;
    live = 0;
    foreach (q[i]) if (!q[i].stale) live++;
    allowed = ((live + (br ? 0 : $countones(busy))) < NR) && (q.size() < NR);
    e_req   = m_pend || (req && allowed);
    ba      = {a[31:2], 2'b00};
    e_addr  = br ? ba : m_next;
    e_valid = rv_eff && !q[0].stale && !br;
    chk("instr_req", 32'(instr_req_o), 32'(e_req));
    chk("instr_addr", instr_addr_o, e_addr);
    chk("fifo_valid", 32'(fifo_valid_o), 32'(e_valid));
    if (e_valid) begin
      chk("fifo_rdata", fifo_rdata_o, rd_of(q[0].addr));
      chk("fifo_err", 32'(fifo_err_o), 32'(err));
    end
    chk("fifo_clear", 32'(fifo_clear_o), 32'(br));
    if (br) chk("fifo_addr", fifo_addr_o, a);
    chk("busy", 32'(busy_o), 32'(e_req || (q.size() > 0)));
`ifdef IBEX_FETCH_PERF_CNT_EN
    chk("perf", perf_gnt_stall_o, m_perf);
`endif
    @(posedge clk_i);
    g = e_req && gnt;
    if (req && !m_req_prev) m_perf = '0;
    else if (m_pend && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
    m_req_prev = req;
    if (rv_eff) void'(q.pop_front());
    if (br) foreach (q[i]) q[i].stale = 1;
    if (g) q.push_back('{addr: e_addr, stale: 0});
    m_next = g ? e_addr + 32'd4 : (br ? ba : m_next);
    m_pend = e_req && !gnt;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() > 0; k++) cycle(0, 0, '0, '0, 0, 1, 0);
  endtask

  initial begin
    logic [31:0] r;
    do_reset();

    // Straight-line fetch; third request waits for the first response.
    repeat (3) cycle(1, 0, '0, '0, 1, 0, 0);
    repeat (4) cycle(1, 0, '0, '0, 1, 1, 0);
    drain();

    // Branch to 0x102 with two responses in flight.
    do_reset();
    repeat (2) cycle(1, 0, '0, '0, 1, 0, 0);
    cycle(1, 1, 32'h0000_0102, '0, 0, 0, 0);
    cycle(0, 0, '0, '0, 1, 1, 0);
    repeat (3) cycle(0, 0, '0, '0, 0, 1, 0);

    // Grant withheld for five cycles, branch to 0x40 in the third.
    do_reset();
    repeat (2) cycle(1, 0, '0, '0, 0, 0, 0);
    cycle(1, 1, 32'h0000_0040, '0, 0, 0, 0);
    repeat (2) cycle(1, 0, '0, '0, 0, 0, 0);
    cycle(1, 0, '0, '0, 1, 0, 0);
    cycle(0, 0, '0, '0, 0, 0, 0);
    drain();

    // Address wrap at the top of memory.
    do_reset();
    cycle(1, 1, 32'hFFFF_FFFC, '0, 1, 0, 0);
    cycle(1, 0, '0, '0, 1, 0, 0);
    cycle(0, 0, '0, '0, 0, 0, 0);
    drain();

    // FIFO occupancy blocks requests until it drains.
    do_reset();
    cycle(1, 0, '0, '0, 1, 0, 0);
    repeat (2) cycle(1, 0, '0, 2'b11, 1, 0, 0);
    cycle(1, 0, '0, 2'b01, 1, 1, 0);
    cycle(1, 0, '0, 2'b01, 1, 0, 0);
    drain();

    // Error response is forwarded and fetching continues.
    do_reset();
    cycle(1, 0, '0, '0, 1, 0, 0);
    cycle(1, 0, '0, '0, 1, 1, 1);
    cycle(1, 0, '0, '0, 1, 0, 0);
    drain();

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      r = $urandom;
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0, r & 32'hFFFF_FFFE,
            NR'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ibex_fetch_req_ctrl.md
Name: ibex_fetch_req_ctrl

Overview:
Instruction-side request controller that sits directly upstream of the fetch FIFO. It issues word-aligned requests on the instruction memory bus and tracks up to NUM_REQS outstanding responses. It discards responses made stale by a branch and pushes the surviving responses into the fetch FIFO's input port. It also drives the FIFO's clear and address on every branch.

Parameters:
NUM_REQS, 2, maximum number of outstanding bus requests; must match the fetch FIFO's NUM_REQS (range 1..4).

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is asynchronous and active-high
req_i  in  1  fetch enable from the IF stage
branch_i  in  1  redirect fetch to addr_i this cycle
addr_i  in  32  branch target (halfword aligned)
fifo_busy_i  in  NUM_REQS  busy vector from the fetch FIFO (upper entries valid)
fifo_clear_o  out  1  clear the FIFO; equals branch_i
fifo_valid_o  out  1  push a response into the FIFO
fifo_addr_o  out  32  equals addr_i; used by the FIFO only on clear
fifo_rdata_o  out  32  equals instr_rdata_i
fifo_err_o  out  1  equals instr_err_i
instr_req_o  out  1  bus request
instr_gnt_i  in  1  bus grant
instr_addr_o  out  32  bus address; [1:0] always 2'b00
instr_rvalid_i  in  1  response valid
instr_rdata_i  in  32  response data
instr_err_i  in  1  response error
busy_o  out  1  high when instr_req_o is high or any response is outstanding

Behaviour:
- State machine, state_q:
  - IDLE: may raise instr_req_o.
  - WAIT_GNT: instr_req_o is held high until granted.
- Transitions:
  - IDLE -> WAIT_GNT when instr_req_o=1 and instr_gnt_i=0.
  - WAIT_GNT -> IDLE on instr_gnt_i=1.
- Request-allowed condition: (count of non-discarded outstanding responses + popcount(fifo_busy_i)) < NUM_REQS, and outstanding_q[NUM_REQS-1]=0.
  - When branch_i=1, the fifo_busy_i term is treated as 0.
- instr_req_o:
  - IDLE: req_i & allowed.
  - WAIT_GNT: always 1, independent of req_i and the allowed condition.
- instr_addr_o:
  - branch_i=1: {addr_i[31:2],2'b00}.
  - otherwise: fetch_addr_q.
  - In WAIT_GNT, instr_addr_o is stable except when branch_i=1; a branch re-targets the pending request and the state stays WAIT_GNT.
- fetch_addr_q:
  - Reset value 0.
  - On grant: loaded with instr_addr_o+4, wrapping 32'hFFFF_FFFC -> 0.
  - On branch_i without a grant: loaded with {addr_i[31:2],2'b00}.
- outstanding_q[NUM_REQS-1:0] (thermometer) and discard_q[NUM_REQS-1:0]:
  - A grant sets the lowest clear outstanding bit.
  - instr_rvalid_i shifts both vectors down by one.
  - Grant and rvalid in the same cycle: shift, then set.
- Discard marking:
  - branch_i sets discard_q for every currently outstanding bit.
  - A request granted in the same cycle as branch_i is not discarded.
  - A response arriving in the same cycle as branch_i is discarded.
- fifo_valid_o = instr_rvalid_i & outstanding_q[0] & ~discard_q[0] & ~branch_i.
- Error responses are forwarded with fifo_err_o=1; err does not halt fetching.
- Reset values: instr_req_o=0, fifo_valid_o=0, busy_o=0, state IDLE, outstanding_q/discard_q all zero.
  - Asserting rst_i mid-transaction aborts everything; later rvalids with no outstanding bit are ignored.
- Latency: response-to-FIFO push is combinational (0 cycles). Grant-to-next-request is 1 cycle minimum, i.e. back-to-back grants are allowed.
- Assertions:
  - rvalid only when outstanding_q[0]=1.
  - instr_req_o never falls in WAIT_GNT.
  - instr_addr_o[1:0]==0.

Optional Feature:
Macro: IBEX_FETCH_PERF_CNT_EN.
- Defined: adds output perf_gnt_stall_o[31:0], a saturating count of cycles spent in WAIT_GNT.
  - Reset value 0.
  - Clears on the first cycle of req_i rising from 0.
  - Holds at 32'hFFFF_FFFF.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package ibex_fetch_pkg holds:
  - the fetch_state_e enum {IDLE, WAIT_GNT};
  - localparam FETCH_WORD_INCR=32'd4;
  - localparam FETCH_MAX_REQS=4.
- One sub-module, ibex_fetch_outstanding_tracker:
  - owns outstanding_q/discard_q;
  - inputs: gnt, rvalid, branch;
  - outputs: vectors, non-discarded count, head_valid.

Test Plan:
1. Reset released, req_i=1, gnt every cycle, fifo_busy_i=0 -> requests at 0x0 and 0x4; third request blocked until the first rvalid; pushes carry the rdata in order.
2. Branch to 0x102 while 2 requests are outstanding -> fifo_clear_o=1, fifo_addr_o=0x102, next instr_addr_o=0x100; the two old rvalids give fifo_valid_o=0; the new response is pushed.
3. gnt withheld 5 cycles -> instr_req_o and instr_addr_o stable for 5 cycles; branch to 0x40 in cycle 3 -> address becomes 0x40, request stays high; with macro defined, perf_gnt_stall_o=5.
4. Start at 0xFFFF_FFFC, gnt -> next address 0x0000_0000.
5. fifo_busy_i=2'b11, one response outstanding -> no request; busy drops to 2'b01 and response returns -> request resumes next cycle.
6. Response with instr_err_i=1 -> fifo_err_o=1 and fifo_valid_o=1; the next request is still issued at +4.
